pixel_write_arbiter: RTL and testbench

Shares the single pixel-write port of the 320x240 `vga_adapter` between three pixel sources: screen clear, brush (draw/erase) and cursor renderer. It arbitrates at burst granularity with fixed priority, so a multi-pixel shape such as the 21x21 cursor cross is never interleaved with other writes. It registers one pixel per cycle onto `vga_x`/`vga_y`/`vga_color`/`vga_write`. It sits between the drawing state machines and `vga_adapter`, and replaces their direct writes to those registers.

---
 rtl/drawing_pkg.sv | 29 ++
 rtl/pixel_arb_prio.sv | 29 ++
 rtl/pixel_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/drawing_pkg.sv
// Shared drawing constants, owner encoding and pixel beat type for the
// drawing pipeline feeding vga_adapter.
package drawing_pkg;

    localparam int unsigned X_BITS     = 9;
    localparam int unsigned Y_BITS     = 8;
    localparam int unsigned COLOR_BITS = 9;
    localparam int unsigned SCR_W      = 320;
    localparam int unsigned SCR_H      = 240;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CLR  = 2'd1,
        OWN_BRS  = 2'd2,
        OWN_CUR  = 2'd3
    } owner_e;

    localparam logic [COLOR_BITS-1:0] DRAW_COLOR   = 9'h1FF;
    localparam logic [COLOR_BITS-1:0] ERASE_COLOR  = 9'h000;
    localparam logic [COLOR_BITS-1:0] CURSOR_COLOR = 9'h1C0;

    typedef struct packed {
        logic [X_BITS-1:0]     x;
        logic [Y_BITS-1:0]     y;
        logic [COLOR_BITS-1:0] color;
        logic                  last;
    } pixel_beat_t;

endpackage

// File: rtl/pixel_arb_prio.sv
// Fixed-priority 3-way grant (clr > brs > cur) with lock override.
// Grant bit order: [0] clr, [1] brs, [2] cur.
module pixel_arb_prio (
    input  logic       rst_i,
    input  logic [2:0] valid_i,
    input  logic [1:0] owner_i,
    output logic [2:0] grant_o
);
    import drawing_pkg::*;

    always_comb begin
        grant_o = '0;
        if (!rst_i) begin
            // A lock holder keeps ready even while its valid is low
            unique case (owner_e'(owner_i))
                OWN_NONE: begin
                    if (valid_i[0])      grant_o = 3'b001;
                    else if (valid_i[1]) grant_o = 3'b010;
                    else if (valid_i[2]) grant_o = 3'b100;
                end
                OWN_CLR: grant_o = 3'b001;
                OWN_BRS: grant_o = 3'b010;
                OWN_CUR: grant_o = 3'b100;
                default: grant_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Burst-granular arbiter sharing the vga_adapter pixel-write port.
// Optional out-of-bounds dropping is enabled by PIXEL_ARB_BOUNDS_CHECK_EN.
module pixel_write_arbiter #(
    parameter int unsigned X_BITS     = drawing_pkg::X_BITS,
    parameter int unsigned Y_BITS     = drawing_pkg::Y_BITS,
    parameter int unsigned COLOR_BITS = drawing_pkg::COLOR_BITS,
    parameter int unsigned SCR_W      = drawing_pkg::SCR_W,
    parameter int unsigned SCR_H      = drawing_pkg::SCR_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_valid,
    input  logic                  clr_last,
    input  logic [X_BITS-1:0]     clr_x,
    input  logic [Y_BITS-1:0]     clr_y,
    input  logic [COLOR_BITS-1:0] clr_color,
    output logic                  clr_ready,
    input  logic                  brs_valid,
    input  logic                  brs_last,
    input  logic [X_BITS-1:0]     brs_x,
    input  logic [Y_BITS-1:0]     brs_y,
    input  logic [COLOR_BITS-1:0] brs_color,
    output logic                  brs_ready,
    input  logic                  cur_valid,
    input  logic                  cur_last,
    input  logic [X_BITS-1:0]     cur_x,
    input  logic [Y_BITS-1:0]     cur_y,
    input  logic [COLOR_BITS-1:0] cur_color,
    output logic                  cur_ready,
    output logic [X_BITS-1:0]     vga_x,
    output logic [Y_BITS-1:0]     vga_y,
    output logic [COLOR_BITS-1:0] vga_color,
    output logic                  vga_write,
    output logic [1:0]            owner,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);
    import drawing_pkg::*;

    owner_e                owner_q, owner_d;
    logic [2:0]            valid, grant, acc;
    logic                  accept;
    logic [X_BITS-1:0]     sel_x;
    logic [Y_BITS-1:0]     sel_y;
    logic [COLOR_BITS-1:0] sel_color;
    logic                  sel_last;
    owner_e                sel_own;
    logic                  in_bounds;

    logic [X_BITS-1:0]     x_q;
    logic [Y_BITS-1:0]     y_q;
    logic [COLOR_BITS-1:0] color_q;
    logic                  write_q;

    assign valid = {cur_valid, brs_valid, clr_valid};

    pixel_arb_prio u_prio (
        .rst_i   (rst),
        .valid_i (valid),
        .owner_i (owner_q),
        .grant_o (grant)
    );

    assign clr_ready = grant[0];
    assign brs_ready = grant[1];
    assign cur_ready = grant[2];
    assign acc       = grant & valid;
    assign accept    = |acc;

    always_comb begin
        sel_x     = clr_x;
        sel_y     = clr_y;
        sel_color = clr_color;
        sel_last  = clr_last;
        sel_own   = OWN_CLR;
        if (acc[1]) begin
            sel_x     = brs_x;
            sel_y     = brs_y;
            sel_color = brs_color;
            sel_last  = brs_last;
            sel_own   = OWN_BRS;
        end else if (acc[2]) begin
            sel_x     = cur_x;
            sel_y     = cur_y;
            sel_color = cur_color;
            sel_last  = cur_last;
            sel_own   = OWN_CUR;
        end
    end

    always_comb begin
        owner_d = owner_q;
        if (accept) begin
            owner_d = sel_last ? OWN_NONE : sel_own;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
    assign in_bounds = ({1'b0, sel_x} < SCR_W[X_BITS:0]) &&
                       ({1'b0, sel_y} < SCR_H[Y_BITS:0]);

    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (accept && !in_bounds && (drop_q != '1)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign in_bounds = 1'b1;
    assign drop_cnt  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            write_q <= 1'b0;
        end else begin
            write_q <= accept && in_bounds;
            if (accept) begin
                x_q     <= sel_x;
                y_q     <= sel_y;
                color_q <= sel_color;
            end
        end
    end

    assign vga_x     = x_q;
    assign vga_y     = y_q;
    assign vga_color = color_q;
    assign vga_write = write_q;
    assign owner     = owner_q;
    assign busy      = (owner_q != OWN_NONE) || write_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter; honours PIXEL_ARB_BOUNDS_CHECK_EN.
module tb_pixel_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_valid, clr_last, brs_valid, brs_last, cur_valid, cur_last;
    logic [8:0] clr_x, brs_x, cur_x;
    logic [7:0] clr_y, brs_y, cur_y;
    logic [8:0] clr_color, brs_color, cur_color;
    logic       clr_ready, brs_ready, cur_ready;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [8:0] vga_color;
    logic       vga_write;
    logic [1:0] owner;
    logic       busy;
    logic [15:0] drop_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    pixel_write_arbiter #(
        .X_BITS(9), .Y_BITS(8), .COLOR_BITS(9), .SCR_W(320), .SCR_H(240)
    ) dut (
        .clk(clk), .rst(rst),
        .clr_valid(clr_valid), .clr_last(clr_last), .clr_x(clr_x), .clr_y(clr_y),
        .clr_color(clr_color), .clr_ready(clr_ready),
        .brs_valid(brs_valid), .brs_last(brs_last), .brs_x(brs_x), .brs_y(brs_y),
        .brs_color(brs_color), .brs_ready(brs_ready),
        .cur_valid(cur_valid), .cur_last(cur_last), .cur_x(cur_x), .cur_y(cur_y),
        .cur_color(cur_color), .cur_ready(cur_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_write(vga_write),
        .owner(owner), .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr_valid = 0; clr_last = 0; clr_x = '0; clr_y = '0; clr_color = '0;
        brs_valid = 0; brs_last = 0; brs_x = '0; brs_y = '0; brs_color = '0;
        cur_valid = 0; cur_last = 0; cur_x = '0; cur_y = '0; cur_color = '0;

        // Reset state, readies held low during reset
        tick();
        clr_valid = 1; clr_last = 1; clr_x = 9'd77;
        settle();
        check("rst_clr_ready", clr_ready, 0);
        tick();
        check("rst_owner", owner, 0);
        check("rst_write", vga_write, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_color", vga_color, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        clr_valid = 0;
        rst = 1'b0;

        // Single clr beat
        clr_valid = 1; clr_last = 1; clr_x = 9'd5; clr_y = 8'd7; clr_color = 9'h1FF;
        settle();
        check("single_ready", clr_ready, 1);
        tick();
        clr_valid = 0;
        check("single_write", vga_write, 1);
        check("single_x", vga_x, 5);
        check("single_y", vga_y, 7);
        check("single_color", vga_color, 9'h1FF);
        check("single_owner", owner, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_write_off", vga_write, 0);
        check("single_x_hold", vga_x, 5);
        check("single_busy_off", busy, 0);

        // 41-beat cursor burst with clr arriving at beat 3
        for (int unsigned i = 1; i <= 41; i++) begin
            cur_valid = 1; cur_last = (i == 41); cur_x = 9'(i); cur_y = 8'(i + 100);
            cur_color = 9'h1C0;
            if (i == 3) begin
                clr_valid = 1; clr_last = 1; clr_x = 9'd200; clr_y = 8'd50; clr_color = 9'h0AA;
            end
            settle();
            check("cur_ready", cur_ready, 1);
            if (i >= 3) check("clr_blocked", clr_ready, 0);
            tick();
            check("cur_write", vga_write, 1);
            check("cur_x", vga_x, i);
            check("cur_y", vga_y, i + 100);
            check("cur_owner", owner, (i == 41) ? 0 : 3);
        end
        cur_valid = 0; cur_last = 0;
        settle();
        check("clr_after_cur", clr_ready, 1);
        tick();
        clr_valid = 0;
        check("clr_nogap_write", vga_write, 1);
        check("clr_nogap_x", vga_x, 200);
        check("clr_nogap_color", vga_color, 9'h0AA);

        // Simultaneous single-beat requests
        clr_valid = 1; clr_last = 1; clr_x = 9'd1; clr_y = 8'd1; clr_color = 9'h001;
        brs_valid = 1; brs_last = 1; brs_x = 9'd2; brs_y = 8'd2; brs_color = 9'h002;
        cur_valid = 1; cur_last = 1; cur_x = 9'd3; cur_y = 8'd3; cur_color = 9'h003;
        settle();
        check("sim1_clr_ready", clr_ready, 1);
        check("sim1_brs_ready", brs_ready, 0);
        check("sim1_cur_ready", cur_ready, 0);
        tick();
        clr_valid = 0;
        check("sim1_x", vga_x, 1);
        check("sim1_owner", owner, 0);
        settle();
        check("sim2_brs_ready", brs_ready, 1);
        check("sim2_cur_ready", cur_ready, 0);
        tick();
        brs_valid = 0;
        check("sim2_x", vga_x, 2);
        check("sim2_owner", owner, 0);
        settle();
        check("sim3_cur_ready", cur_ready, 1);
        tick();
        cur_valid = 0;
        check("sim3_x", vga_x, 3);
        check("sim3_write", vga_write, 1);
        check("sim3_owner", owner, 0);

        // Brush lock held while its valid drops
        brs_valid = 1; brs_last = 0; brs_x = 9'd10; brs_y = 8'd20; brs_color = 9'h0F0;
        tick();
        brs_valid = 0;
        cur_valid = 1; cur_last = 1; cur_x = 9'd99; cur_y = 8'd9; cur_color = 9'h1C0;
        check("lock_write", vga_write, 1);
        check("lock_owner", owner, 2);
        for (int unsigned k = 0; k < 5; k++) begin
            settle();
            check("lock_cur_ready", cur_ready, 0);
            check("lock_brs_ready", brs_ready, 1);
            tick();
            check("lock_idle_write", vga_write, 0);
            check("lock_idle_owner", owner, 2);
            check("lock_busy", busy, 1);
        end
        brs_valid = 1; brs_last = 1; brs_x = 9'd11;
        tick();
        brs_valid = 0;
        check("unlock_x", vga_x, 11);
        check("unlock_owner", owner, 0);
        settle();
        check("unlock_cur_ready", cur_ready, 1);
        tick();
        cur_valid = 0;
        check("unlock_cur_x", vga_x, 99);

        // Out-of-bounds beats
        clr_valid = 1; clr_last = 1; clr_x = 9'd320; clr_y = 8'd0; clr_color = 9'h111;
        settle();
        check("oob1_ready", clr_ready, 1);
        tick();
        clr_x = 9'd0; clr_y = 8'd240;
`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
        check("oob1_write", vga_write, 0);
        check("oob1_drop", drop_cnt, 1);
`else
        check("oob1_write", vga_write, 1);
        check("oob1_x", vga_x, 320);
`endif
        settle();
        check("oob2_ready", clr_ready, 1);
        tick();
        clr_valid = 0;
`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
        check("oob2_write", vga_write, 0);
        check("oob2_drop", drop_cnt, 2);
`else
        check("oob2_write", vga_write, 1);
        check("oob2_y", vga_y, 240);
        check("oob2_drop", drop_cnt, 0);
`endif

        // Reset in the middle of a cursor burst
        cur_valid = 1; cur_last = 0; cur_x = 9'd30; cur_y = 8'd31; cur_color = 9'h1C0;
        tick();
        cur_x = 9'd31;
        check("mid_owner", owner, 3);
        tick();
        rst = 1'b1;
        cur_x = 9'd32;
        settle();
        check("mid_rst_ready", cur_ready, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_owner", owner, 0);
        check("mid_rst_write", vga_write, 0);
        check("mid_rst_x", vga_x, 0);
        check("mid_rst_color", vga_color, 0);
        check("mid_rst_busy", busy, 0);
        brs_valid = 1; brs_last = 1; brs_x = 9'd44; brs_y = 8'd4; brs_color = 9'h044;
        cur_last = 1;
        settle();
        check("post_rst_brs_ready", brs_ready, 1);
        check("post_rst_cur_ready", cur_ready, 0);
        tick();
        brs_valid = 0;
        check("post_rst_x", vga_x, 44);
        check("post_rst_write", vga_write, 1);
        tick();
        cur_valid = 0;
        check("post_rst_cur_x", vga_x, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
